seg_digit_sequencer: RTL

//   Schedules 4-bit codes into the 7-segment decoder (code[0..3] -> Z,O,E,f decoder inputs).

---
 rtl/seg_digit_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg_digit_sequencer.sv
// seg_digit_sequencer
//   Playback sequencer feeding 4-bit codes to the 7-segment decoder.
//   Codes are appended to a small buffer through a valid/ready write port while
//   IDLE. On start, each entry is shown for DWELL_CYCLES clocks. Playback wraps
//   to entry 0 until stop is asserted. pause (level) freezes playback.
//
//   Optional feature macro: SEG_BLINK_EN
//     defined   : code_valid drops for the second half of each dwell period
//                 (dwell >= DWELL_CYCLES/2), so every entry blinks once.
//     undefined : code_valid stays high throughout RUN and HOLD.
//
//   state_dbg exposes the FSM state (0 = IDLE, 1 = RUN, 2 = HOLD).

module seg_digit_sequencer #(
    parameter int DWELL_CYCLES = 1000,  // >= 2
    parameter int DEPTH        = 8      // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     reset,
    // Write handshake: a code is accepted on any rising edge where
    // wr_valid && wr_ready. wr_ready is combinational and never depends on
    // wr_valid. It is high only in IDLE with free space. wr_valid may be held
    // while wr_ready is low. Nothing is accepted until wr_ready rises.
    input  logic                     wr_valid,
    input  logic [3:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     stop,
    output logic [3:0]               code,
    output logic                     code_valid,
    output logic                     busy,
    output logic                     wrapped,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state_dbg
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int DW   = $clog2(DWELL_CYCLES);
    localparam int HALF = DWELL_CYCLES / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [DW-1:0]  dwell;

    logic           wr_fire;
    logic           dwell_last;
    logic [AW-1:0]  ptr_nxt;
    logic [DW-1:0]  dwell_adv;

    assign state_dbg = state;

    // Write acceptance and playback step decode
    always_comb begin
        wr_ready   = (state == IDLE) && (count < CW'(DEPTH));
        wr_fire    = wr_valid && wr_ready;
        dwell_last = (dwell == DW'(DWELL_CYCLES - 1));
        ptr_nxt    = (CW'(rd_ptr) == (count - 1'b1)) ? '0 : rd_ptr + 1'b1;
        dwell_adv  = dwell_last ? '0 : dwell + 1'b1;
    end

    // Buffer storage. Clear wins over a same-cycle write, so the write is dropped.
    always_ff @(posedge clk) begin
        if (wr_fire && !clear) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    // Control FSM with registered outputs, fill count, read pointer and dwell timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            dwell      <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            case (state)
                IDLE: begin
                    // Clear also suppresses start, so playback never begins on an empty buffer.
                    if (clear) begin
                        count <= '0;
                    end else begin
                        if (wr_fire) begin
                            count <= count + 1'b1;
                        end
                        if (start && ((count != '0) || wr_fire)) begin
                            state      <= RUN;
                            busy       <= 1'b1;
                            code_valid <= 1'b1;
                            dwell      <= '0;
                            rd_ptr     <= '0;
                            // An empty buffer's first entry is the write landing this edge.
                            code       <= (count == '0) ? wr_data : mem[0];
                        end
                    end
                end
                RUN, HOLD: begin
                    if (stop) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        code       <= '0;
                        code_valid <= 1'b0;
                        dwell      <= '0;
                        rd_ptr     <= '0;
                    end else begin
                        state <= pause ? HOLD : RUN;
                        // The timer advances on every edge where pause is low. A HOLD cycle
                        // whose pause has already dropped therefore counts. No dwell cycle is
                        // lost or added across a pause.
                        if (!pause) begin
                            dwell <= dwell_adv;
                            if (dwell_last) begin
                                rd_ptr  <= ptr_nxt;
                                code    <= mem[ptr_nxt];
                                wrapped <= (ptr_nxt == '0);
                            end
`ifdef SEG_BLINK_EN
                            code_valid <= (dwell_adv < DW'(HALF));
`else
                            code_valid <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
